// File: rtl/key_debounce.sv
// Single-key debouncer: 2-flop synchronizer, counter-based 4-state filter FSM,
// registered level output and one-cycle press/release pulses.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 240000,
    parameter int unsigned CNT_W        = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_FILT = 2'd1;
    localparam logic [1:0] DOWN       = 2'd2;
    localparam logic [1:0] REL_FILT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync1;
    logic             sync2;
    logic             key_s;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Synchronizer idles at 1 so a reset looks like a released key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign key_s = sync2;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nx = PRESS_FILT;
                    cnt_nx   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DOWN;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_nx = REL_FILT;
                    cnt_nx   = '0;
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs are decoded from the next state so they line up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_level   <= (state_nx == DOWN) || (state_nx == REL_FILT);
            key_press   <= (state == PRESS_FILT) && (state_nx == DOWN);
            key_release <= (state == REL_FILT) && (state_nx == IDLE);
        end
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Single-key debouncer and edge detector that turns a raw, asynchronous, bouncing push-button into clean synchronous signals. It sits directly upstream of the dff2 flip-flop stage: `key_level` or `key_press` drives that stage's `d` input in the same `clk` domain. Inside the block, the raw key passes through a 2-flop synchronizer, then a counter-based 4-state filter FSM, then registered level and pulse outputs.

## Interface
Parameters:
- DEBOUNCE_CNT, default 240000 (20 ms at 12 MHz): number of consecutive stable synchronized samples needed to accept a change. Legal range is 2 or more. Simulation uses 4.
- CNT_W, default 18: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CNT-1.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- key_n, input, 1: raw button, active-low (0 = pressed). Asynchronous to clk.
- key_level, output, 1: debounced key state, 1 = pressed.
- key_press, output, 1: one-cycle pulse on an accepted press.
- key_release, output, 1: one-cycle pulse on an accepted release.

## Operation
- Synchronizer:
  - sync1 <= key_n; sync2 <= sync1.
  - key_s = sync2, the only signal the FSM sees.
  - Both flops reset to 1 (released).
- FSM states: IDLE, PRESS_FILT, DOWN, REL_FILT. Reset state is IDLE, cnt = 0.
- IDLE:
  - key_s = 0: go to PRESS_FILT, cnt <= 0.
  - Otherwise: stay.
- PRESS_FILT:
  - key_s = 1: go to IDLE, cnt <= 0. No output activity; this is a bounce.
  - key_s = 0 and cnt = DEBOUNCE_CNT-1: go to DOWN.
  - Otherwise: cnt <= cnt+1.
- DOWN:
  - key_s = 1: go to REL_FILT, cnt <= 0.
  - Otherwise: stay.
- REL_FILT:
  - key_s = 0: return to DOWN, cnt <= 0. No output activity.
  - key_s = 1 and cnt = DEBOUNCE_CNT-1: go to IDLE.
  - Otherwise: cnt <= cnt+1.
- Outputs (all registered, no combinational path from key_n):
  - key_level = 1 exactly while the state is DOWN or REL_FILT.
  - key_press = 1 for the single cycle after the PRESS_FILT→DOWN transition.
  - key_release = 1 for the single cycle after the REL_FILT→IDLE transition.
  - key_press and key_release are never high together and never high in consecutive cycles.
- cnt saturates by construction: it never exceeds DEBOUNCE_CNT-1 and never wraps.

## Timing
- Reset values: key_level = 0, key_press = 0, key_release = 0, state IDLE, cnt = 0, sync1 = sync2 = 1.
- Reset asserted mid-operation (any state): every output drops to its reset value immediately, asynchronously. No pending pulse is emitted afterwards.
- Press latency. Edge 0 is the first rising edge that samples key_n = 0.
  - key_s = 0 after edge 1.
  - PRESS_FILT is entered at edge 2.
  - DOWN, key_level = 1 and key_press = 1 all appear at edge DEBOUNCE_CNT+2.
  - key_press clears at edge DEBOUNCE_CNT+3.
- Release latency is symmetric: key_level = 0 and key_release = 1 at edge DEBOUNCE_CNT+2 after the first sample of key_n = 1.
- A change in key_n is accepted only if it stays stable for DEBOUNCE_CNT+1 consecutive synchronized samples.
  - Any shorter excursion is fully absorbed.
  - Each excursion restarts the count from 0.
- Key held low when rst_n deasserts: treated as a fresh press. key_press fires DEBOUNCE_CNT+2 edges after the first post-reset sample.

## Test plan
All scenarios use DEBOUNCE_CNT = 4 and a 20 ns clk.
- Reset: rst_n = 0 with key_n toggling → key_level = 0, key_press = 0, key_release = 0 throughout. After release with key_n = 1, outputs stay 0.
- Clean press: key_n goes 1→0 and is held → key_level rises and key_press is high for exactly 1 cycle at edge 6 after the first low sample. key_release stays 0.
- Bouncy press: key_n low 2 cycles, high 1, low 3, high 1, then low and held → no pulses during the bounce. key_press fires exactly once, 6 edges after the final falling transition.
- Clean release after a stable press: key_n goes 0→1 and is held → key_release is high for 1 cycle at edge 6. key_level falls on the same edge.
- Release glitch: in DOWN, key_n high for 3 cycles then low → key_level stays 1 and no pulses occur.
- Async reset mid-filter: rst_n pulsed low at cnt = 2 in PRESS_FILT → outputs go 0 immediately. With key_n held low, key_press fires 6 edges after the first post-reset sample.
